// File: rtl/mem_bank_arb_pkg.sv
// Shared definitions for the memory-bank arbiter.
// Holds the FSM state encoding, the default parameter values used by
// mem_bank_arb, and the fixed widths of the grant index and latency counter.
package mem_bank_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_NUM_PORTS = 2;
    localparam int DEF_LATENCY   = 2;

    // grant_id is 3 bits wide to cover up to 8 ports; the counter covers LATENCY-1 up to 14.
    localparam int GID_W = 3;
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_bank_arb_rr_arbiter.sv
// Round-robin arbiter (combinational).
// Ports:
//   req        - per-port request vector
//   last_grant - index of the most recently granted port
//   grant      - one-hot grant vector (all zero when no request)
//   grant_idx  - index of the granted port (0 when no request)
//   any_req    - at least one request is pending
// The search starts at (last_grant+1) mod NUM_PORTS and wraps around.
module rr_arbiter
    import mem_bank_arb_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [GID_W-1:0]     last_grant,
    output logic [NUM_PORTS-1:0] grant,
    output logic [GID_W-1:0]     grant_idx,
    output logic                 any_req
);

    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        // Outer loop walks the priority order; the first requesting port in it wins.
        for (int i = 1; i <= NUM_PORTS; i++) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (!found && req[j] && (((int'(last_grant) + i) % NUM_PORTS) == j)) begin
                    found     = 1'b1;
                    grant[j]  = 1'b1;
                    grant_idx = GID_W'(j);
                end
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/mem_bank_arb.sv
// Single-bank memory shared by NUM_PORTS requesters through a round-robin
// arbiter. Each access is latched at grant, commits LATENCY edges later and
// is acknowledged with a one-cycle ready pulse to the winning port.
// Ports:
//   clock, reset          - clock and asynchronous active-high reset
//   req_rd, req_wr        - per-port read / write requests (both set = write)
//   req_addr, req_wdata   - packed per-port address and write data
//   ready                 - per-port completion pulse
//   rd_data               - read data, held until the next read
//   busy                  - access in progress
//   grant_id              - index of the granted port
//   parity_err            - (MEM_BANK_ARB_PARITY_EN only) stored parity mismatch on a read
// Optional feature: define MEM_BANK_ARB_PARITY_EN to store an even-parity bit per word.
module mem_bank_arb
    import mem_bank_arb_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int LATENCY   = DEF_LATENCY
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          req_rd,
    input  logic [NUM_PORTS-1:0]          req_wr,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
    output logic [NUM_PORTS-1:0]          ready,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          busy,
`ifdef MEM_BANK_ARB_PARITY_EN
    output logic                          parity_err,
`endif
    output logic [GID_W-1:0]              grant_id
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef MEM_BANK_ARB_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [GID_W-1:0]   last_grant;
    logic               op_wr;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [MEM_W-1:0]   mem [DEPTH];

    logic [NUM_PORTS-1:0] req_any;
    logic [NUM_PORTS-1:0] grant;
    logic [GID_W-1:0]     grant_idx;
    logic                 any_req;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic                 sel_wr;
    logic [NUM_PORTS-1:0] done_vec;
    logic                 launch;
    logic                 commit;

    assign req_any = req_rd | req_wr;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
        .req        (req_any),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any_req    (any_req)
    );

    // Operand mux of the winning port; a simultaneous read+write is a write.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        done_vec  = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (grant[j]) begin
                sel_addr  = req_addr[j*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[j*DATA_W +: DATA_W];
                sel_wr    = req_wr[j];
            end
            done_vec[j] = (grant_id == GID_W'(j));
        end
    end

    assign launch = (state != BUSY) && any_req;
    assign commit = (state == BUSY) && (cnt == '0);

    // Operands are latched at grant so later input changes do not matter.
    always_ff @(posedge clock) begin
        if (launch) begin
            op_wr   <= sel_wr;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
        end
    end

    // Array has no reset so contents survive it; an aborted access never reaches commit.
    always_ff @(posedge clock) begin
        if (commit && op_wr) begin
`ifdef MEM_BANK_ARB_PARITY_EN
            mem[addr_q] <= {^wdata_q, wdata_q};
`else
            mem[addr_q] <= wdata_q;
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= GID_W'(NUM_PORTS - 1);
            grant_id   <= '0;
            ready      <= '0;
            rd_data    <= '0;
            busy       <= 1'b0;
`ifdef MEM_BANK_ARB_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            ready <= '0;
`ifdef MEM_BANK_ARB_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE, DONE: begin
                    if (any_req) begin
                        state      <= BUSY;
                        busy       <= 1'b1;
                        grant_id   <= grant_idx;
                        last_grant <= grant_idx;
                        cnt        <= CNT_W'(LATENCY - 1);
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        ready <= done_vec;
                        if (!op_wr) begin
                            rd_data <= mem[addr_q][DATA_W-1:0];
`ifdef MEM_BANK_ARB_PARITY_EN
                            // Even parity over data+parity bit must reduce to 0.
                            parity_err <= ^mem[addr_q];
`endif
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bank_arb.sv
// Self-checking bench for mem_bank_arb (default parameters).
// Expected completions are pushed to a scoreboard queue when a request is
// driven and popped when the DUT raises ready.
module tb_mem_bank_arb;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 8;
    localparam int NUM_PORTS = 2;
    localparam int LATENCY   = 2;

    logic                        clock = 1'b0;
    logic                        reset;
    logic [NUM_PORTS-1:0]        req_rd;
    logic [NUM_PORTS-1:0]        req_wr;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS*DATA_W-1:0] req_wdata;
    logic [NUM_PORTS-1:0]        ready;
    logic [DATA_W-1:0]           rd_data;
    logic                        busy;
    logic [2:0]                  grant_id;
`ifdef MEM_BANK_ARB_PARITY_EN
    logic                        parity_err;
`endif

    mem_bank_arb #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .NUM_PORTS (NUM_PORTS),
        .LATENCY   (LATENCY)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_rd     (req_rd),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .ready      (ready),
        .rd_data    (rd_data),
        .busy       (busy),
`ifdef MEM_BANK_ARB_PARITY_EN
        .parity_err (parity_err),
`endif
        .grant_id   (grant_id)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          port;
        logic        is_rd;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model [256];
    logic [15:0] model_rd;
    int          checks = 0;
    int          errors = 0;

    // Drive one request and push its expected completion.
    task automatic issue(input int p, input logic rd, input logic wr,
                         input logic [7:0] a, input logic [15:0] d);
        exp_t e;
        req_rd[p] = rd;
        req_wr[p] = wr;
        req_addr[p*ADDR_W +: ADDR_W]  = a;
        req_wdata[p*DATA_W +: DATA_W] = d;
        e.port  = p;
        e.is_rd = rd && !wr;
        if (wr) model[a] = d;
        else    model_rd = model[a];
        e.data = model_rd;
        sb.push_back(e);
    endtask

    task automatic drop(input int p);
        req_rd[p] = 1'b0;
        req_wr[p] = 1'b0;
    endtask

    // Waits (bounded) for any ready bit; n counts negedges from the call.
    task automatic wait_ready(output int n, output logic to, output logic b2);
        n  = 0;
        to = 1'b1;
        b2 = 1'b0;
        while (to && n < 40) begin
            @(negedge clock);
            n++;
            if (n == 2) b2 = busy;
            if (ready != '0) to = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_rd = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        model_rd = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if (ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", ready); end
        checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 0000", rd_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
`ifdef MEM_BANK_ARB_PARITY_EN
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
`endif
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_simultaneous();
        int n; logic to, b2; exp_t e; logic [1:0] er;
        issue(0, 1'b0, 1'b1, 8'h01, 16'h1111);
        issue(1, 1'b0, 1'b1, 8'h02, 16'h2222);
        for (int k = 0; k < 2; k++) begin
            wait_ready(n, to, b2);
            e = sb.pop_front(); er = '0; er[e.port] = 1'b1;
            checks++; if (ready !== er) begin errors++; $display("FAIL simul_ready_%0d: got %b want %b", k, ready, er); end
            checks++; if (grant_id !== 3'(k)) begin errors++; $display("FAIL simul_grant_id_%0d: got %0d want %0d", k, grant_id, k); end
            drop(e.port);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_basic();
        int n; logic to, b2; exp_t e;
        issue(0, 1'b0, 1'b1, 8'h10, 16'hBEEF);
        wait_ready(n, to, b2);
        e = sb.pop_front();
        checks++; if (to || n != LATENCY + 2) begin errors++; $display("FAIL basic_wr_latency: got %0d negedges want %0d", n, LATENCY + 2); end
        checks++; if (b2 !== 1'b1) begin errors++; $display("FAIL basic_wr_busy: got %b want 1", b2); end
        checks++; if (ready !== 2'b01) begin errors++; $display("FAIL basic_wr_ready: got %b want 01", ready); end
        drop(0);
        @(posedge clock); #1;
        issue(0, 1'b1, 1'b0, 8'h10, 16'h0000);
        wait_ready(n, to, b2);
        e = sb.pop_front();
        checks++; if (to || n != LATENCY + 2) begin errors++; $display("FAIL basic_rd_latency: got %0d negedges want %0d", n, LATENCY + 2); end
        checks++; if (ready !== 2'b01) begin errors++; $display("FAIL basic_rd_ready: got %b want 01", ready); end
        checks++; if (rd_data !== e.data) begin errors++; $display("FAIL basic_rd_data: got %h want %h", rd_data, e.data); end
        drop(0);
        @(negedge clock);
        checks++; if (ready !== 2'b00) begin errors++; $display("FAIL basic_ready_pulse: got %b want 00", ready); end
        @(posedge clock); #1;
    endtask

    task automatic test_hold_rd_data();
        int n; logic to, b2; exp_t e;
        issue(1, 1'b0, 1'b1, 8'h11, 16'h7777);
        wait_ready(n, to, b2);
        e = sb.pop_front();
        checks++; if (ready !== 2'b10) begin errors++; $display("FAIL hold_ready: got %b want 10", ready); end
        checks++; if (rd_data !== e.data) begin errors++; $display("FAIL hold_after_write: got %h want %h", rd_data, e.data); end
        drop(1);
        repeat (3) @(negedge clock);
        checks++; if (rd_data !== e.data) begin errors++; $display("FAIL hold_idle: got %h want %h", rd_data, e.data); end
        @(posedge clock); #1;
    endtask

    task automatic test_rdwr_both();
        int n; logic to, b2; exp_t e;
        issue(1, 1'b1, 1'b1, 8'h00, 16'h00AA);
        wait_ready(n, to, b2);
        e = sb.pop_front();
        checks++; if (rd_data !== e.data) begin errors++; $display("FAIL both_is_write: got %h want %h", rd_data, e.data); end
        drop(1);
        @(posedge clock); #1;
        issue(1, 1'b1, 1'b0, 8'h00, 16'h0000);
        wait_ready(n, to, b2);
        e = sb.pop_front();
        checks++; if (ready !== 2'b10) begin errors++; $display("FAIL both_rd_ready: got %b want 10", ready); end
        checks++; if (rd_data !== e.data) begin errors++; $display("FAIL both_readback: got %h want %h", rd_data, e.data); end
        drop(1);
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back();
        int n; logic to, b2; exp_t e; logic [1:0] er; int last;
        last = 0;
        issue(0, 1'b0, 1'b1, 8'h20, 16'hA000);
        issue(1, 1'b0, 1'b1, 8'h30, 16'hB000);
        for (int i = 0; i < 4; i++) begin
            wait_ready(n, to, b2);
            e = sb.pop_front(); er = '0; er[e.port] = 1'b1;
            checks++; if (ready !== er) begin errors++; $display("FAIL b2b_ready_%0d: got %b want %b", i, ready, er); end
            checks++; if (grant_id !== 3'(e.port)) begin errors++; $display("FAIL b2b_grant_%0d: got %0d want %0d", i, grant_id, e.port); end
            if (i > 0) begin
                checks++; if (cyc - last != LATENCY + 1) begin errors++; $display("FAIL b2b_spacing_%0d: got %0d cycles want %0d", i, cyc - last, LATENCY + 1); end
            end
            last = cyc;
            drop(e.port);
            @(posedge clock); #1;
            if (i == 0) issue(0, 1'b0, 1'b1, 8'h21, 16'hA001);
            else if (i == 1) issue(1, 1'b0, 1'b1, 8'h31, 16'hB001);
        end
        issue(0, 1'b1, 1'b0, 8'h31, 16'h0000);
        wait_ready(n, to, b2);
        e = sb.pop_front();
        checks++; if (rd_data !== e.data) begin errors++; $display("FAIL b2b_readback: got %h want %h", rd_data, e.data); end
        drop(0);
        @(posedge clock); #1;
    endtask

    task automatic test_reset_abort();
        int n; logic to, b2; exp_t e;
        issue(0, 1'b0, 1'b1, 8'hFF, 16'h5555);
        wait_ready(n, to, b2); e = sb.pop_front(); drop(0);
        @(posedge clock); #1;
        issue(0, 1'b1, 1'b0, 8'h00, 16'h0000);
        wait_ready(n, to, b2); e = sb.pop_front(); drop(0);
        @(posedge clock); #1;
        // Write that must never commit; not pushed to the scoreboard.
        req_wr[0] = 1'b1;
        req_addr[0 +: ADDR_W]  = 8'hFF;
        req_wdata[0 +: DATA_W] = 16'h1234;
        @(posedge clock);
        @(negedge clock);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b want 1", busy); end
        reset = 1'b1;
        drop(0);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (ready !== 2'b00) begin errors++; $display("FAIL abort_ready: got %b want 00", ready); end
        checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL abort_rd_data: got %h want 0000", rd_data); end
        checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL abort_grant_id: got %0d want 0", grant_id); end
        model_rd = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;
        issue(1, 1'b1, 1'b0, 8'hFF, 16'h0000);
        wait_ready(n, to, b2);
        e = sb.pop_front();
        checks++; if (ready !== 2'b10) begin errors++; $display("FAIL abort_rd_ready: got %b want 10", ready); end
        checks++; if (rd_data !== e.data) begin errors++; $display("FAIL abort_retained: got %h want %h", rd_data, e.data); end
        drop(1);
        @(posedge clock); #1;
    endtask

`ifdef MEM_BANK_ARB_PARITY_EN
    task automatic test_parity();
        int n; logic to, b2; exp_t e;
        issue(0, 1'b0, 1'b1, 8'h40, 16'h0F0F);
        wait_ready(n, to, b2); e = sb.pop_front(); drop(0);
        @(posedge clock); #1;
        dut.mem[64][DATA_W] = ~dut.mem[64][DATA_W];
        issue(0, 1'b1, 1'b0, 8'h40, 16'h0000);
        wait_ready(n, to, b2); e = sb.pop_front();
        checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL parity_flip: got %b want 1", parity_err); end
        checks++; if (rd_data !== e.data) begin errors++; $display("FAIL parity_flip_data: got %h want %h", rd_data, e.data); end
        drop(0);
        @(posedge clock); #1;
        issue(0, 1'b1, 1'b0, 8'h10, 16'h0000);
        wait_ready(n, to, b2); e = sb.pop_front();
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL parity_clean: got %b want 0", parity_err); end
        drop(0);
        @(posedge clock); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_simultaneous();
        test_basic();
        test_hold_rd_data();
        test_rdwr_both();
        test_back_to_back();
        test_reset_abort();
`ifdef MEM_BANK_ARB_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_bank_arb.md
MEM_BANK_ARB -- requirements
Module: mem_bank_arb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning address width; depth is 2**ADDR_W words.
REQ-003 The block SHALL have parameter NUM_PORTS, default 2 (legal 1..8), meaning number of requester channels.
REQ-004 The block SHALL have parameter LATENCY, default 2 (legal 1..15), meaning cycles from grant to completion.
REQ-005 The block SHALL have port clock, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-007 The block SHALL have port req_rd, input, NUM_PORTS, meaning per-port read request.
REQ-008 The block SHALL have port req_wr, input, NUM_PORTS, meaning per-port write request.
REQ-009 The block SHALL have port req_addr, input, NUM_PORTS*ADDR_W, meaning packed per-port address, port p at bits [p*ADDR_W +: ADDR_W].
REQ-010 The block SHALL have port req_wdata, input, NUM_PORTS*DATA_W, meaning packed per-port write data.
REQ-011 The block SHALL have port ready, output, NUM_PORTS, meaning one-cycle per-port completion pulse.
REQ-012 The block SHALL have port rd_data, output, DATA_W, meaning read data, valid while ready is high.
REQ-013 The block SHALL have port busy, output, 1, meaning an access is in progress.
REQ-014 The block SHALL have port grant_id, output, 3, meaning index of the granted port.

Function
REQ-015 The FSM SHALL have states IDLE, BUSY, DONE.
REQ-016 In IDLE or DONE, at a rising edge with any request pending, the block SHALL latch winner index, op, address and write data, load counter with LATENCY-1, and enter BUSY; with no request it SHALL enter IDLE.
REQ-017 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NUM_PORTS; last_grant updates on each grant.
REQ-018 In BUSY the counter SHALL decrement each edge; at the edge where counter is 0 the access SHALL commit (write to array, or read into rd_data register) and the FSM SHALL enter DONE.
REQ-019 ready[grant_id] SHALL be high for exactly the DONE cycle; all other ready bits SHALL be 0.
REQ-020 Request sampled at edge k SHALL produce ready high in the cycle after edge k+LATENCY; back-to-back throughput SHALL be one access per LATENCY+1 cycles.
REQ-021 A requester SHALL hold req and operands stable until ready and drop req in the ready cycle; latched operands SHALL make later input changes irrelevant.
REQ-022 req_rd and req_wr both high on one port SHALL be executed as a write.
REQ-023 rd_data SHALL hold its last read value after a write or when idle.
REQ-024 busy SHALL be high in BUSY only.
REQ-025 Address arithmetic SHALL be unsigned; all 2**ADDR_W locations SHALL be addressable with no wrap or aliasing.

Reset
REQ-026 On reset: state IDLE, ready 0, rd_data 0, busy 0, grant_id 0, counter 0, last_grant NUM_PORTS-1.
REQ-027 Reset mid-BUSY SHALL abort the access; an uncommitted write SHALL not modify the array.
REQ-028 Array contents SHALL be retained across reset.

Configuration
REQ-029 With MEM_BANK_ARB_PARITY_EN defined the array SHALL store an even-parity bit per word and an extra output parity_err (1 bit, reset 0) SHALL pulse with ready on a read whose stored parity mismatches; without the macro neither the bit nor the port SHALL exist.

Structure
REQ-030 A shared package SHALL hold the FSM state enumeration and the default parameter constants.
REQ-031 The round-robin arbiter SHALL be a sub-module rr_arbiter (request vector plus last_grant in, one-hot grant and index out, combinational).

Verification
REQ-032 Port 0 writes 0xBEEF to addr 0x10, then reads it, LATENCY=2 -> ready[0] in cycle after edge k+2 each time; rd_data=0xBEEF.
REQ-033 Ports 0 and 1 request in same cycle after reset -> port 0 granted first, port 1 next; grant_id 0 then 1.
REQ-034 Both ports request continuously for 4 accesses -> grants alternate 0,1,0,1; one ready per 3 cycles.
REQ-035 reset asserted in BUSY of a write of 0x1234 to addr 0xFF -> outputs zero immediately; later read of 0xFF returns prior value.
REQ-036 Port 1 asserts req_rd and req_wr with data 0x00AA at addr 0x00 -> read-back returns 0x00AA.
REQ-037 With MEM_BANK_ARB_PARITY_EN, force a stored parity bit flip, read -> parity_err=1 with ready; clean read -> parity_err=0.
